// File: rtl/mc_ctrl_pkg.sv
// Shared types for the multi-cycle control unit: state codes and instruction classes.
package mc_ctrl_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned CLS_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_ERR    = 3'd7
  } state_t;

  typedef enum logic [CLS_W-1:0] {
    CLS_ALU    = 2'b00,
    CLS_LOAD   = 2'b01,
    CLS_STORE  = 2'b10,
    CLS_BRANCH = 2'b11
  } cls_t;

endpackage

// File: rtl/mc_wait_timer.sv
// Counts consecutive memory-stall cycles; expire flags the cycle that would reach MAX.
module mc_wait_timer #(
  parameter int unsigned MAX = 8,
  parameter int unsigned W   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + W'(1);
    end
  end

  // clr carries mem_rdy, so a handshake in the timeout cycle wins
  assign expire = inc & ~clr & (cnt == W'(MAX - 1));

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle CPU control sequencer with memory handshake, stall timeout and halt at boundaries.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 8,
  parameter int unsigned CNT_W        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             safe,
  input  logic [CLS_W-1:0] ins_class,
  input  logic             mem_rdy,
  input  logic             halt_req,
  output logic             write_pc,
  output logic             pc_sel_br,
  output logic             write_ir,
  output logic             write_reg,
  output logic             la,
  output logic             lb,
  output logic             lc,
  output logic             lf,
  output logic             mem_req,
  output logic             mem_we,
  output logic             busy,
  output logic             err,
  output logic [STATE_W-1:0] state_o
);

  state_t state, state_n;
  cls_t   class_q;
  logic   in_mem_phase;
  logic   tmr_clr;
  logic   tmr_inc;
  logic   expire;

  // Counter only runs while waiting in FETCH/MEM; any other state leaves it zeroed for the next entry
  assign in_mem_phase = (state == ST_FETCH) || (state == ST_MEM);
  assign tmr_clr      = mem_rdy | ~in_mem_phase;
  assign tmr_inc      = in_mem_phase & ~mem_rdy;

  mc_wait_timer #(
    .MAX (MEM_WAIT_MAX),
    .W   (CNT_W)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .inc    (tmr_inc),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      class_q <= CLS_ALU;
    end else begin
      state <= state_n;
      if (state == ST_DECODE) begin
        class_q <= cls_t'(ins_class);
      end
    end
  end

  // Next-state and strobe decode; strobes are Mealy on the current state and handshake
  always_comb begin
    state_n   = state;
    write_pc  = 1'b0;
    pc_sel_br = 1'b0;
    write_ir  = 1'b0;
    write_reg = 1'b0;
    la        = 1'b0;
    lb        = 1'b0;
    lc        = 1'b0;
    lf        = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    busy      = 1'b0;
    err       = 1'b0;

    unique case (state)
      ST_IDLE: begin
        state_n = ST_FETCH;
      end
      ST_FETCH: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        if (mem_rdy && safe) begin
          write_ir = 1'b1;
          write_pc = 1'b1;
          state_n  = ST_DECODE;
        end else if (expire) begin
          state_n = ST_ERR;
        end
      end
      ST_DECODE: begin
        busy    = 1'b1;
        la      = 1'b1;
        lb      = 1'b1;
        lc      = 1'b1;
        state_n = ST_EXEC;
      end
      ST_EXEC: begin
        busy = 1'b1;
        unique case (class_q)
          CLS_ALU: begin
            lf      = 1'b1;
            state_n = ST_WB;
          end
          CLS_LOAD, CLS_STORE: begin
            state_n = ST_MEM;
          end
          CLS_BRANCH: begin
            write_pc  = 1'b1;
            pc_sel_br = 1'b1;
            state_n   = halt_req ? ST_HALT : ST_FETCH;
          end
          default: state_n = ST_ERR;
        endcase
      end
      ST_MEM: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        mem_we  = (class_q == CLS_STORE);
        if (mem_rdy) begin
          if (class_q == CLS_LOAD) begin
            state_n = ST_WB;
          end else begin
            state_n = halt_req ? ST_HALT : ST_FETCH;
          end
        end else if (expire) begin
          state_n = ST_ERR;
        end
      end
      ST_WB: begin
        busy      = 1'b1;
        write_reg = 1'b1;
        state_n   = halt_req ? ST_HALT : ST_FETCH;
      end
      ST_HALT: begin
        if (!halt_req) begin
          state_n = ST_FETCH;
        end
      end
      ST_ERR: begin
        err = 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign state_o = STATE_W'(state);

endmodule
